// File: rtl/wave_pwm_dac_if.sv
// Sample/control bundle between the wave sources, the PWM output stage and its consumers.
// master drives run control and sample; slave (the DAC stage) returns PWM state.
interface wave_pwm_dac_if;
    logic       en;
    logic [7:0] wave;
    logic [1:0] amp;
    logic       pwm_out;
    logic       sample_req;
    logic [7:0] duty;

    modport master (
        output en, wave, amp,
        input  pwm_out, sample_req, duty
    );

    modport slave (
        input  en, wave, amp,
        output pwm_out, sample_req, duty
    );
endinterface

// File: rtl/wave_pwm_dac.sv
// Function-generator output stage: scales an 8-bit sample about mid-scale and
// emits it as single-bit PWM, pacing the upstream source with one sample_req per period.
module wave_pwm_dac #(
    parameter int unsigned PRESCALE = 1
) (
    input logic          clk,
    input logic          rst,
    wave_pwm_dac_if.slave bus
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty;
    logic             pwm_out;
    logic             sample_req;

    logic             tick;
    logic             boundary;
    logic signed [9:0] s;
    logic signed [9:0] shifted;
    logic [7:0]       scaled;

    always_comb begin
        tick     = bus.en && (pre_cnt == PRE_MAX);
        boundary = tick && (pwm_cnt == 8'd255);
    end

    // Arithmetic shift of the centred sample keeps the result inside 0..255 for every amp.
    always_comb begin
        s       = $signed({2'b00, bus.wave}) - 10'sd128;
        shifted = '0;
        case (bus.amp)
            2'd3:    shifted = s;
            2'd2:    shifted = s >>> 1;
            2'd1:    shifted = s >>> 2;
            default: shifted = '0;
        endcase
        scaled = 8'(shifted + 10'sd128);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
            duty       <= 8'd128;
            pwm_cnt    <= '1;
            pre_cnt    <= PRE_MAX;
        end else if (!bus.en) begin
            // Park counters so the first enabled edge lands on a period boundary.
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
            pwm_cnt    <= '1;
            pre_cnt    <= PRE_MAX;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (boundary) begin
                duty <= scaled;
            end
            sample_req <= boundary;
            pwm_out    <= (pwm_cnt < duty);
        end
    end

    assign bus.pwm_out    = pwm_out;
    assign bus.sample_req = sample_req;
    assign bus.duty       = duty;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Self-checking bench for wave_pwm_dac: table-driven scaling vectors, scoreboard of
// expected duty values popped on each sample_req, and hand-written timing sequences.
module tb_wave_pwm_dac;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wave_pwm_dac_if b1();
    wave_pwm_dac_if b4();

    wave_pwm_dac #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    wave_pwm_dac #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    logic       sel;
    logic       mon_pwm;
    logic       mon_req;
    logic [7:0] mon_duty;
    assign mon_pwm  = sel ? b4.pwm_out    : b1.pwm_out;
    assign mon_req  = sel ? b4.sample_req : b1.sample_req;
    assign mon_duty = sel ? b4.duty       : b1.duty;

    int errors = 0;
    int checks = 0;
    int sb[$];

    typedef struct {
        int wave;
        int amp;
        int duty;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_duty(input string name);
        int exp;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got duty %0d expected scoreboard entry (queue empty)", name, mon_duty);
        end else begin
            exp = sb.pop_front();
            check(name, 32'(mon_duty), 32'(exp));
        end
    endtask

    task automatic wait_req(input string name, input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (mon_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_req_seen"}, 32'(got), 32'd1);
    endtask

    // Starts at a negedge where sample_req is high; ends at the next one.
    task automatic measure(input string name, input int period, input int exp_high);
        int highs;
        int early;
        bit last;
        highs = 0;
        early = 0;
        last  = 1'b0;
        for (int i = 1; i <= period; i++) begin
            @(negedge clk);
            if (mon_pwm === 1'b1) highs++;
            if (i < period && mon_req !== 1'b0) early++;
            if (i == period) last = (mon_req === 1'b1);
        end
        check({name, "_high_clocks"}, 32'(highs), 32'(exp_high));
        check({name, "_req_early"}, 32'(early), 32'd0);
        check({name, "_req_spacing"}, 32'(last), 32'd1);
    endtask

    function automatic int model(input int w, input int a);
        int s, d, q;
        if (a == 0) return 128;
        s = w - 128;
        d = 1 << (3 - a);
        q = s / d;
        if (s < 0 && q * d != s) q = q - 1;
        return 128 + q;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int early;
        int w;
        int a;

        tbl[0] = '{200, 2, 164};
        tbl[1] = '{0,   2, 64};
        tbl[2] = '{0,   1, 96};
        tbl[3] = '{255, 1, 159};
        tbl[4] = '{77,  0, 128};
        tbl[5] = '{255, 0, 128};
        tbl[6] = '{0,   3, 0};
        tbl[7] = '{255, 3, 255};
        tbl[8] = '{128, 3, 128};

        sel     = 1'b0;
        rst     = 1'b1;
        b1.en   = 1'b1;
        b1.wave = 8'd200;
        b1.amp  = 2'd3;
        b4.en   = 1'b0;
        b4.wave = 8'd0;
        b4.amp  = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_pwm_out", 32'(mon_pwm), 32'd0);
        check("rst_sample_req", 32'(mon_req), 32'd0);
        check("rst_duty", 32'(mon_duty), 32'd128);

        // T1: first edge after reset release is a boundary
        sb.push_back(200);
        rst = 1'b0;
        @(negedge clk);
        check("t1_first_req", 32'(mon_req), 32'd1);
        expect_duty("t1_duty");
        measure("t1_p1", 256, 200);
        measure("t1_p2", 256, 200);

        // T2/T3: scaling table and extremes
        for (int i = 0; i < 9; i++) begin
            b1.wave = 8'(tbl[i].wave);
            b1.amp  = 2'(tbl[i].amp);
            sb.push_back(tbl[i].duty);
            wait_req($sformatf("tbl%0d", i), 300);
            expect_duty($sformatf("tbl%0d_duty", i));
            measure($sformatf("tbl%0d", i), 256, tbl[i].duty);
        end

        for (int i = 0; i < 4; i++) begin
            w = int'($urandom_range(0, 255));
            a = int'($urandom_range(0, 3));
            b1.wave = 8'(w);
            b1.amp  = 2'(a);
            sb.push_back(model(w, a));
            wait_req($sformatf("rnd%0d", i), 600);
            expect_duty($sformatf("rnd%0d_w%0d_a%0d_duty", i, w, a));
        end

        // T4: mid-period wave change takes effect only at the next boundary
        b1.wave = 8'd200;
        b1.amp  = 2'd3;
        sb.push_back(200);
        wait_req("t4", 600);
        expect_duty("t4_old_duty");
        bad   = 0;
        early = 0;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            if (i == 100) begin
                b1.wave = 8'd50;
                sb.push_back(50);
            end
            if (i < 256) begin
                if (mon_duty !== 8'd200) bad++;
                if (mon_req !== 1'b0) early++;
            end else begin
                check("t4_req_spacing", 32'(mon_req), 32'd1);
                expect_duty("t4_new_duty");
            end
        end
        check("t4_duty_held", 32'(bad), 32'd0);
        check("t4_req_early", 32'(early), 32'd0);

        // T5: reset mid-period
        b1.wave = 8'd200;
        sb.push_back(200);
        wait_req("t5", 600);
        expect_duty("t5_pre_duty");
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_pwm_out", 32'(mon_pwm), 32'd0);
        check("t5_rst_duty", 32'(mon_duty), 32'd128);
        check("t5_rst_req", 32'(mon_req), 32'd0);
        rst = 1'b0;
        sb.push_back(200);
        @(negedge clk);
        check("t5_boundary_req", 32'(mon_req), 32'd1);
        expect_duty("t5_post_duty");

        // T6: PRESCALE=4 instance
        b1.en   = 1'b0;
        sel     = 1'b1;
        b4.wave = 8'd128;
        b4.amp  = 2'd3;
        b4.en   = 1'b1;
        sb.push_back(128);
        wait_req("t6", 2000);
        expect_duty("t6_duty");
        measure("t6_mid", 1024, 512);
        repeat (300) @(negedge clk);
        b4.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mon_pwm !== 1'b0 || mon_req !== 1'b0) bad++;
        end
        check("t6_idle_outputs", 32'(bad), 32'd0);
        check("t6_idle_duty_held", 32'(mon_duty), 32'd128);
        check("t6_p1_idle_pwm", 32'(b1.pwm_out), 32'd0);
        b4.wave = 8'd255;
        b4.en   = 1'b1;
        sb.push_back(255);
        @(negedge clk);
        check("t6_reenable_req", 32'(mon_req), 32'd1);
        expect_duty("t6_reenable_duty");
        measure("t6_full", 1024, 1020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
